// File: rtl/svm_alpha_update_pkg.sv
// Shared definitions for the SMO alpha-pair update engine.
// Holds the FSM state encoding, default word/fraction widths and the label encoding.
package svm_alpha_update_pkg;

  localparam int unsigned DefW    = 64;
  localparam int unsigned DefFrac = 32;

  // Label bit value meaning class +1 (0 means -1).
  localparam logic LabelPos = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StBound,
    StCheck,
    StDiv,
    StClip,
    StUpd,
    StDone
  } state_e;

endpackage

// File: rtl/svm_alpha_update_if.sv
// Request/response bundle between the SVM control FSM and the alpha update engine.
//   cal_start            : request pulse (master -> slave)
//   a1, a2               : current alphas
//   label1, label2       : class labels, 1 = +1, 0 = -1
//   err1, err2           : prediction errors
//   eta                  : K11 + K22 - 2*K12
//   c_val                : box constraint C
//   new_a1, new_a2       : updated alphas (slave -> master)
//   cal_finish           : one-cycle completion pulse
//   busy                 : engine not idle
//   skipped              : no update performed, valid with cal_finish
interface svm_alpha_update_if #(
  parameter int unsigned W = 64
) ();

  logic         cal_start;
  logic [W-1:0] a1;
  logic [W-1:0] a2;
  logic         label1;
  logic         label2;
  logic [W-1:0] err1;
  logic [W-1:0] err2;
  logic [W-1:0] eta;
  logic [W-1:0] c_val;
  logic [W-1:0] new_a1;
  logic [W-1:0] new_a2;
  logic         cal_finish;
  logic         busy;
  logic         skipped;

  modport master (
    output cal_start, a1, a2, label1, label2, err1, err2, eta, c_val,
    input  new_a1, new_a2, cal_finish, busy, skipped
  );

  modport slave (
    input  cal_start, a1, a2, label1, label2, err1, err2, eta, c_val,
    output new_a1, new_a2, cal_finish, busy, skipped
  );

endinterface

// File: rtl/svm_div_unsigned.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
//   clk, rst_  : clock, asynchronous active-low reset
//   start      : load operands (ignored bits of a running division are discarded)
//   dividend   : DW-bit unsigned dividend
//   divisor    : VW-bit unsigned divisor, must be non-zero
//   done       : high during the cycle whose clock edge completes the last iteration
//   quotient   : valid after the edge on which done was high, held until next start
module svm_div_unsigned #(
  parameter int unsigned DW = 96,
  parameter int unsigned VW = 64
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          done,
  output logic [DW-1:0] quotient
);

  localparam int unsigned CW = $clog2(DW + 1);

  // Dividend bits shift out of the top while quotient bits shift into the bottom.
  logic [DW-1:0] dvd_q;
  logic [VW-1:0] rem_q;
  logic [VW-1:0] dsr_q;
  logic [CW-1:0] cnt_q;

  logic [VW:0]   rem_shift;
  logic [VW:0]   trial;
  logic          ge;

  assign rem_shift = {rem_q, dvd_q[DW-1]};
  assign trial     = rem_shift - {1'b0, dsr_q};
  // rem_shift < 2*divisor, so a clear borrow bit means the subtraction fits.
  assign ge        = ~trial[VW];

  assign done     = (cnt_q == CW'(1));
  assign quotient = dvd_q;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      dvd_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      dvd_q <= dividend;
      rem_q <= '0;
      dsr_q <= divisor;
      cnt_q <= CW'(DW);
    end else if (cnt_q != '0) begin
      dvd_q <= {dvd_q[DW-2:0], ge};
      rem_q <= ge ? trial[VW-1:0] : rem_shift[VW-1:0];
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/svm_alpha_update.sv
// SMO alpha-pair update engine: captures one request, computes the L/H window, the
// step delta = y2*(E1-E2)/eta, clips the new a2 and derives the compensating a1.
//   clk, rst_  : clock, asynchronous active-low reset
//   bus        : svm_alpha_update_if slave (request inputs, result outputs, handshake)
module svm_alpha_update
  import svm_alpha_update_pkg::*;
#(
  parameter int unsigned W    = DefW,
  parameter int unsigned FRAC = DefFrac
) (
  input  logic               clk,
  input  logic               rst_,
  svm_alpha_update_if.slave  bus
);

  localparam int unsigned DW = W + FRAC;
  localparam logic signed [W-1:0] SMax = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SMin = {1'b1, {(W-1){1'b0}}};

  state_e state_q;

  logic signed [W-1:0] a1_q, a2_q, e1_q, e2_q, eta_q, c_q;
  logic                y1_q, y2_q;
  logic signed [W-1:0] lo_q, hi_q;
  logic signed [W:0]   diff_q;
  logic signed [W-1:0] res_a2_q;
  logic signed [W-1:0] new_a1_q, new_a2_q;
  logic                skipped_q, finish_q, busy_q;

  // L/H window, evaluated two bits wider so no intermediate sum wraps.
  logic signed [W+1:0] a1x, a2x, cx, lo_raw, hi_raw;
  logic signed [W-1:0] lo_n, hi_n;
  logic signed [W:0]   diff_n;

  assign a1x = {{2{a1_q[W-1]}}, a1_q};
  assign a2x = {{2{a2_q[W-1]}}, a2_q};
  assign cx  = {{2{c_q[W-1]}}, c_q};

  always_comb begin
    if (y1_q != y2_q) begin
      lo_raw = a2x - a1x;
      hi_raw = cx + a2x - a1x;
    end else begin
      lo_raw = a1x + a2x - cx;
      hi_raw = a1x + a2x;
    end
  end

  // Both bounds are clamped into [0, C]; a bound pushed outside the box still
  // yields lo >= hi, so the skip decision is unchanged while both fit in W bits.
  always_comb begin
    lo_n = lo_raw[W-1:0];
    if (lo_raw[W+1]) begin
      lo_n = '0;
    end else if (lo_raw > cx) begin
      lo_n = c_q;
    end
    hi_n = hi_raw[W-1:0];
    if (hi_raw[W+1]) begin
      hi_n = '0;
    end else if (hi_raw > cx) begin
      hi_n = c_q;
    end
  end

  assign diff_n = {e1_q[W-1], e1_q} - {e2_q[W-1], e2_q};

  logic skip;
  assign skip = eta_q[W-1] || (eta_q == '0) || (lo_q >= hi_q);

  // |E1-E2| never exceeds 2^W-1, so W bits hold the magnitude.
  logic [W-1:0]  abs_mag;
  logic [DW-1:0] dividend;
  logic [DW-1:0] quotient;
  logic          div_start, div_done;

  assign abs_mag   = diff_q[W] ? W'(-diff_q) : W'(diff_q);
  assign dividend  = {abs_mag, {FRAC{1'b0}}};
  assign div_start = (state_q == StCheck) && !skip;

  svm_div_unsigned #(
    .DW(DW),
    .VW(W)
  ) u_div (
    .clk      (clk),
    .rst_     (rst_),
    .start    (div_start),
    .dividend (dividend),
    .divisor  (eta_q),
    .done     (div_done),
    .quotient (quotient)
  );

  // Signed, saturated delta and the clipped a2.
  logic                neg, q_big;
  logic signed [W-1:0] delta, a2raw, clip_n, upd_n;
  logic signed [W:0]   sum;

  assign neg   = diff_q[W] ^ (y2_q != LabelPos);
  assign q_big = |quotient[DW-1:W-1];

  always_comb begin
    if (q_big) begin
      delta = neg ? SMin : SMax;
    end else begin
      delta = neg ? -quotient[W-1:0] : quotient[W-1:0];
    end
  end

  assign sum    = {a2_q[W-1], a2_q} + {delta[W-1], delta};
  assign a2raw  = (sum[W] != sum[W-1]) ? (sum[W] ? SMin : SMax) : sum[W-1:0];
  assign clip_n = (a2raw > hi_q) ? hi_q : ((a2raw < lo_q) ? lo_q : a2raw);

  // Exact modulo 2^W; the true result lies in range whenever the inputs do.
  assign upd_n = (y1_q == y2_q) ? (a1_q + (a2_q - res_a2_q)) : (a1_q - (a2_q - res_a2_q));

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q   <= StIdle;
      a1_q      <= '0;
      a2_q      <= '0;
      e1_q      <= '0;
      e2_q      <= '0;
      eta_q     <= '0;
      c_q       <= '0;
      y1_q      <= 1'b0;
      y2_q      <= 1'b0;
      lo_q      <= '0;
      hi_q      <= '0;
      diff_q    <= '0;
      res_a2_q  <= '0;
      new_a1_q  <= '0;
      new_a2_q  <= '0;
      skipped_q <= 1'b0;
      finish_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      finish_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.cal_start) begin
            a1_q    <= bus.a1;
            a2_q    <= bus.a2;
            e1_q    <= bus.err1;
            e2_q    <= bus.err2;
            eta_q   <= bus.eta;
            c_q     <= bus.c_val;
            y1_q    <= bus.label1;
            y2_q    <= bus.label2;
            busy_q  <= 1'b1;
            state_q <= StBound;
          end
        end
        StBound: begin
          lo_q    <= lo_n;
          hi_q    <= hi_n;
          diff_q  <= diff_n;
          state_q <= StCheck;
        end
        StCheck: begin
          if (skip) begin
            new_a1_q  <= a1_q;
            new_a2_q  <= a2_q;
            skipped_q <= 1'b1;
            finish_q  <= 1'b1;
            state_q   <= StDone;
          end else begin
            state_q <= StDiv;
          end
        end
        StDiv: begin
          if (div_done) begin
            state_q <= StClip;
          end
        end
        StClip: begin
          res_a2_q <= clip_n;
          state_q  <= StUpd;
        end
        StUpd: begin
          new_a1_q  <= upd_n;
          new_a2_q  <= res_a2_q;
          skipped_q <= 1'b0;
          finish_q  <= 1'b1;
          state_q   <= StDone;
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.new_a1     = new_a1_q;
  assign bus.new_a2     = new_a2_q;
  assign bus.skipped    = skipped_q;
  assign bus.cal_finish = finish_q;
  assign bus.busy       = busy_q;

endmodule
